// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode/state enums and default width for the ALU execute stage
package alu_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    HOLD = 2'b10
  } alu_state_e;

endpackage

// File: rtl/alu_exec_stage_if.sv
// rtl/alu_exec_stage_if.sv - operand/result handshake bundle between register file, execute stage and consumer
interface alu_exec_stage_if import alu_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  alu_op_e               opcode;
  logic [DATA_WIDTH-1:0] operand_a;
  logic [DATA_WIDTH-1:0] operand_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] result;
  logic                  carry;
  logic                  zero;

  // Upstream/consumer side: presents ops and accepts results.
  modport master (
    output in_valid, opcode, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, carry, zero
  );

  // Execute stage side.
  modport slave (
    input  in_valid, opcode, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, carry, zero
  );

endinterface

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - unsigned shift-add multiplier, DATA_WIDTH partial products, product valid with done
module seq_multiplier #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] acc;
  logic [2*DATA_WIDTH-1:0] acc_next;
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]        cnt;
  logic                    busy;

  // The last partial product is added combinationally so the owner can
  // register the full product in the same cycle done is high.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign done     = busy && (cnt == CNT_W'(1));
  assign product  = acc_next;

  // Partial product 0 is folded in at start; remaining bits shift through one per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      acc    <= b[0] ? {{DATA_WIDTH{1'b0}}, a} : '0;
      mcand  <= {{(DATA_WIDTH-1){1'b0}}, a, 1'b0};
      mplier <= {1'b0, b[DATA_WIDTH-1:1]};
      cnt    <= CNT_W'(DATA_WIDTH-1);
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with held result; MUL built only when ALU_MUL_EN is defined
module alu_exec_stage import alu_pkg::*; #(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input logic             clk,
  input logic             rst,
  alu_exec_stage_if.slave bus
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_state_e            state, state_next;
  logic                  accept;
  logic                  mul_accept;
  logic [SHAMT_W-1:0]    shamt;
  logic [DATA_WIDTH:0]   alu_wide;
  logic [DATA_WIDTH:0]   shr_wide;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  carry_q;
  logic                  zero_q;

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == HOLD);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign shamt  = bus.operand_b[SHAMT_W-1:0];
  // A trailing guard bit catches the last bit shifted out on the right.
  assign shr_wide = {bus.operand_a, 1'b0} >> shamt;

`ifdef ALU_MUL_EN
  logic                    mul_done;
  logic [2*DATA_WIDTH-1:0] mul_product;

  assign mul_accept = accept && (bus.opcode == OP_MUL);

  seq_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_accept),
    .a       (bus.operand_a),
    .b       (bus.operand_b),
    .done    (mul_done),
    .product (mul_product)
  );
`else
  assign mul_accept = 1'b0;
`endif

  // Single-cycle ops: bit DATA_WIDTH of alu_wide is the carry/borrow/shift-out flag.
  always_comb begin
    alu_wide = '0;
    case (bus.opcode)
      OP_ADD:  alu_wide = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
      OP_SUB:  alu_wide = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
      OP_AND:  alu_wide = {1'b0, bus.operand_a & bus.operand_b};
      OP_OR:   alu_wide = {1'b0, bus.operand_a | bus.operand_b};
      OP_XOR:  alu_wide = {1'b0, bus.operand_a ^ bus.operand_b};
      OP_SHL:  alu_wide = {1'b0, bus.operand_a} << shamt;
      OP_SHR:  alu_wide = {shr_wide[0], shr_wide[DATA_WIDTH:1]};
      default: alu_wide = '0;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: accept only in IDLE, hold the result until the consumer takes it.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = mul_accept ? BUSY : HOLD;
`ifdef ALU_MUL_EN
      BUSY: if (mul_done) state_next = HOLD;
`endif
      HOLD: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Result/flag registers load only at completion, so they stay frozen in HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept && !mul_accept) begin
      result_q <= alu_wide[DATA_WIDTH-1:0];
      carry_q  <= alu_wide[DATA_WIDTH];
      zero_q   <= (alu_wide[DATA_WIDTH-1:0] == '0);
    end
`ifdef ALU_MUL_EN
    else if ((state == BUSY) && mul_done) begin
      result_q <= mul_product[DATA_WIDTH-1:0];
      carry_q  <= |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
      zero_q   <= (mul_product[DATA_WIDTH-1:0] == '0);
    end
`endif
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - scoreboard bench for alu_exec_stage (DATA_WIDTH=8)
module tb_alu_exec_stage;
  import alu_pkg::*;

`ifdef ALU_MUL_EN
  localparam int MUL_LAT = 8;
`else
  localparam int MUL_LAT = 1;
`endif

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    int         lat;
    int         acc_cyc;
  } sb_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic prev_valid = 1'b0;
  logic rand_ready = 1'b0;
  sb_t  sb[$];

  alu_exec_stage_if #(.DATA_WIDTH(8)) bus ();

  alu_exec_stage #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic sb_t model(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    sb_t e;
    int  ia, ib, n, r, c;
    ia = int'(a); ib = int'(b); n = ib % 8; r = 0; c = 0;
    case (op)
      OP_ADD: begin r = (ia + ib) % 256; c = (ia + ib > 255) ? 1 : 0; end
      OP_SUB: begin r = (ia - ib + 256) % 256; c = (ia < ib) ? 1 : 0; end
      OP_AND: r = ia & ib;
      OP_OR:  r = ia | ib;
      OP_XOR: r = ia ^ ib;
      OP_SHL: begin r = (ia << n) % 256; c = (n == 0) ? 0 : ((ia >> (8 - n)) & 1); end
      OP_SHR: begin r = ia >> n; c = (n == 0) ? 0 : ((ia >> (n - 1)) & 1); end
      default: begin
`ifdef ALU_MUL_EN
        r = (ia * ib) % 256; c = ((ia * ib) >= 256) ? 1 : 0;
`else
        r = 0; c = 0;
`endif
      end
    endcase
    e.res = 8'(r);
    e.c   = c[0];
    e.z   = (r == 0);
    e.lat = (op == OP_MUL) ? MUL_LAT : 1;
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic send_op(input alu_op_e op, input logic [7:0] a, input logic [7:0] b);
    sb_t e;
    int  waited;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.opcode    = op;
    bus.operand_a = a;
    bus.operand_b = b;
    waited = 0;
    while (!bus.in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    e = model(op, a, b);
    @(posedge clk);
    #1;
    e.acc_cyc = cyc;
    sb.push_back(e);
    bus.in_valid  = 1'b0;
    bus.opcode    = alu_op_e'($urandom_range(0, 7));
    bus.operand_a = 8'($urandom);
    bus.operand_b = 8'($urandom);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_eq("drain", sb.size(), 0);
  endtask

  // Monitor: latency at rising out_valid, data on each handshake.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (bus.out_valid && !prev_valid) begin
        if (sb.size() == 0) check_eq("unexpected_valid", 32'd1, 32'd0);
        else check_eq("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
      end
      if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("result", bus.result, e.res);
        check_eq("carry", bus.carry, e.c);
        check_eq("zero", bus.zero, e.z);
      end
      prev_valid = bus.out_valid;
    end
  end

  // Random consumer backpressure during the random phase.
  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.opcode    = OP_ADD;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b0;

    #12;
    check_eq("rst_in_ready", bus.in_ready, 0);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_result", bus.result, 0);
    check_eq("rst_carry", bus.carry, 0);
    check_eq("rst_zero", bus.zero, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("in_ready_after_rst", bus.in_ready, 1);

    send_op(OP_ADD, 8'hF0, 8'h20);
    send_op(OP_SUB, 8'h05, 8'h05);
    send_op(OP_SUB, 8'h03, 8'h05);
    send_op(OP_SHL, 8'h81, 8'h01);
    send_op(OP_SHR, 8'h81, 8'h00);
    send_op(OP_SHR, 8'h81, 8'h07);
    send_op(OP_SHL, 8'h81, 8'h07);
    send_op(OP_AND, 8'hCC, 8'hAA);
    send_op(OP_OR,  8'h0C, 8'h30);
    send_op(OP_XOR, 8'h5A, 8'h5A);
    send_op(OP_MUL, 8'h10, 8'h11);
    send_op(OP_MUL, 8'hFF, 8'hFF);
    send_op(OP_MUL, 8'h03, 8'h05);
    drain();

    // Backpressure: result held, next op waits for HOLD->IDLE.
    bus.out_ready = 1'b0;
    send_op(OP_ADD, 8'h01, 8'h01);
    fork
      send_op(OP_ADD, 8'h03, 8'h04);
    join_none
    repeat (3) begin
      @(negedge clk);
      #1;
      check_eq("bp_out_valid", bus.out_valid, 1);
      check_eq("bp_in_ready", bus.in_ready, 0);
      check_eq("bp_result", bus.result, 8'h02);
    end
    bus.out_ready = 1'b1;
    wait fork;
    drain();

    // Random ops under random consumer backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++)
      send_op(alu_op_e'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    drain();
    rand_ready = 1'b0;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset in the middle of a MUL discards it immediately.
    send_op(OP_MUL, 8'h10, 8'h11);
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    sb.delete();
    #1;
    check_eq("midrst_out_valid", bus.out_valid, 0);
    check_eq("midrst_result", bus.result, 0);
    check_eq("midrst_carry", bus.carry, 0);
    check_eq("midrst_zero", bus.zero, 0);
    check_eq("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check_eq("postrst_in_ready", bus.in_ready, 1);
    check_eq("postrst_out_valid", bus.out_valid, 0);
    send_op(OP_ADD, 8'h7F, 8'h01);
    drain();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
